// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the AVR-subset core sequencer:
//   - external phase codes seen by the control decoder (estado)
//   - internal sequencer state encoding
//   - default execute-index width
//   - phase_of(): maps an internal state onto the external phase code
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int EXW_DEF = 2;

    localparam logic [1:0] PH_FETCH   = 2'b00;
    localparam logic [1:0] PH_DECODE  = 2'b01;
    localparam logic [1:0] PH_EXECUTE = 2'b10;
    localparam logic [1:0] PH_WRITEB  = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WRITEB = 3'd3,
        ST_IRQ    = 3'd4,
        ST_SLEEP  = 3'd5
    } seq_state_e;

    // IRQ entry reuses the EXECUTE phase (PC push goes through the ALU/stack
    // path); SLEEP shows FETCH so the decoder raises no strobes.
    function automatic logic [1:0] phase_of(input seq_state_e s);
        logic [1:0] ph;
        case (s)
            ST_FETCH:  ph = PH_FETCH;
            ST_DECODE: ph = PH_DECODE;
            ST_EXEC:   ph = PH_EXECUTE;
            ST_WRITEB: ph = PH_WRITEB;
            ST_IRQ:    ph = PH_EXECUTE;
            ST_SLEEP:  ph = PH_FETCH;
            default:   ph = PH_FETCH;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/cpu_sequencer_wait_ctr.sv
// -----------------------------------------------------------------------------
// seq_wait_ctr
//   DataMem wait-state counter with timeout for the cycle sequencer.
//   Counts cycles spent waiting for mem_ready in the last execute cycle and
//   saturates at MEM_TMO; tmo flags that the wait budget is exhausted.
// Ports:
//   CLK   in  core clock
//   RST   in  synchronous active-low reset
//   hold  in  freeze the counter this cycle (stall)
//   step  in  1 = another wait cycle is being spent; 0 = clear the counter
//   tmo   out counter has reached MEM_TMO
// -----------------------------------------------------------------------------
module seq_wait_ctr
    import cpu_pkg::*;
#(
    parameter int MEM_TMO = 15
) (
    input  logic CLK,
    input  logic RST,
    input  logic hold,
    input  logic step,
    output logic tmo
);

    logic [3:0] wait_q;
    logic [3:0] wait_d;

    assign tmo = (wait_q >= 4'(MEM_TMO));

    always_comb begin
        wait_d = wait_q;
        if (!step) begin
            wait_d = '0;
        end else if (!tmo) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wait_q <= '0;
        end else if (!hold) begin
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//   Cycle sequencer for the AVR-subset core. Produces the 2-bit phase code
//   (estado) consumed by the control decoder, plus execute index, IRQ entry,
//   SLEEP and completion indications. Handles multi-cycle execute, DataMem
//   wait states with timeout, stalls, SLEEP and interrupt entry.
// Ports:
//   CLK, RST     clock, synchronous active-low reset
//   run          sequencing enable (0 = return to/hold FETCH)
//   stall        freeze state and counters this cycle, suppress pulses
//   ex_len       execute cycles minus 1        (sampled in DECODE)
//   mem_req      DataMem access in last execute (sampled in DECODE)
//   mem_ready    DataMem access complete
//   wb_skip      no write-back phase            (sampled in DECODE)
//   sleep_req    SLEEP instruction              (sampled in DECODE)
//   irq, irq_en  level interrupt request and global enable
//   estado       phase code 00 FETCH 01 DECODE 10 EXECUTE 11 WRITEB
//   ex_idx       execute cycle index (0 outside EXEC)
//   irq_cycle    IRQ entry in progress
//   irq_ack      pulse on last IRQ entry cycle
//   instr_done   pulse on last cycle of each instruction
//   sleeping     SLEEP state
//   mem_err      sticky DataMem timeout flag
// -----------------------------------------------------------------------------
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int EXW     = EXW_DEF,
    parameter int MEM_TMO = 15,
    parameter int IRQ_CYC = 2
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           run,
    input  logic           stall,
    input  logic [EXW-1:0] ex_len,
    input  logic           mem_req,
    input  logic           mem_ready,
    input  logic           wb_skip,
    input  logic           sleep_req,
    input  logic           irq,
    input  logic           irq_en,
    output logic [1:0]     estado,
    output logic [EXW-1:0] ex_idx,
    output logic           irq_cycle,
    output logic           irq_ack,
    output logic           instr_done,
    output logic           sleeping,
    output logic           mem_err
);

    localparam int IRQ_W = (IRQ_CYC > 1) ? $clog2(IRQ_CYC) : 1;

    seq_state_e     state_q,   state_d;
    logic [EXW-1:0] ex_idx_q,  ex_idx_d;
    logic [EXW-1:0] ex_len_q,  ex_len_d;
    logic           mem_req_q, mem_req_d;
    logic           wb_skip_q, wb_skip_d;
    logic           sleep_q,   sleep_d;
    logic [IRQ_W-1:0] irq_cnt_q, irq_cnt_d;
    logic           mem_err_q, mem_err_d;

    logic       ex_last;
    logic       in_mem_wait;
    logic       tmo;
    logic       mem_done;
    logic       exec_end;
    logic       instr_end;
    logic       irq_take;
    logic       irq_last;
    logic       wait_step;
    seq_state_e boundary_next;

    seq_wait_ctr #(
        .MEM_TMO (MEM_TMO)
    ) u_wait_ctr (
        .CLK  (CLK),
        .RST  (RST),
        .hold (stall),
        .step (wait_step),
        .tmo  (tmo)
    );

    always_comb begin
        ex_last     = (ex_idx_q == ex_len_q);
        in_mem_wait = (state_q == ST_EXEC) && ex_last && mem_req_q;
        // Timeout releases the access exactly as if mem_ready had arrived.
        mem_done    = !mem_req_q || mem_ready || tmo;
        exec_end    = (state_q == ST_EXEC) && ex_last && mem_done;
        instr_end   = (state_q == ST_WRITEB) || (exec_end && wb_skip_q);
        irq_take    = irq && irq_en;
        irq_last    = (state_q == ST_IRQ) && (irq_cnt_q == IRQ_W'(IRQ_CYC - 1));
        // Counter only advances while genuinely waiting; any other cycle clears it.
        wait_step   = in_mem_wait && !mem_done && run;

        // Interrupt entry takes priority over a pending SLEEP.
        if (irq_take) begin
            boundary_next = ST_IRQ;
        end else if (sleep_q) begin
            boundary_next = ST_SLEEP;
        end else begin
            boundary_next = ST_FETCH;
        end
    end

    always_comb begin
        state_d   = state_q;
        ex_idx_d  = ex_idx_q;
        ex_len_d  = ex_len_q;
        mem_req_d = mem_req_q;
        wb_skip_d = wb_skip_q;
        sleep_d   = sleep_q;
        irq_cnt_d = irq_cnt_q;
        mem_err_d = mem_err_q;

        // Dropping run abandons the instruction, but an IRQ entry already
        // under way must finish its stack push.
        if (!run && (state_q != ST_IRQ)) begin
            state_d  = ST_FETCH;
            ex_idx_d = '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    state_d = ST_DECODE;
                end
                ST_DECODE: begin
                    ex_len_d  = ex_len;
                    mem_req_d = mem_req;
                    wb_skip_d = wb_skip;
                    sleep_d   = sleep_req;
                    ex_idx_d  = '0;
                    state_d   = ST_EXEC;
                end
                ST_EXEC: begin
                    if (!ex_last) begin
                        ex_idx_d = ex_idx_q + EXW'(1);
                    end else if (mem_done) begin
                        ex_idx_d = '0;
                        state_d  = wb_skip_q ? boundary_next : ST_WRITEB;
                        if (mem_req_q && !mem_ready && tmo) begin
                            mem_err_d = 1'b1;
                        end
                    end
                end
                ST_WRITEB: begin
                    state_d = boundary_next;
                end
                ST_IRQ: begin
                    if (irq_last) begin
                        irq_cnt_d = '0;
                        state_d   = ST_FETCH;
                    end else begin
                        irq_cnt_d = irq_cnt_q + IRQ_W'(1);
                    end
                end
                ST_SLEEP: begin
                    if (irq_take) begin
                        state_d = ST_IRQ;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // Stall freezes every register; reset overrides stall.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_FETCH;
            ex_idx_q  <= '0;
            ex_len_q  <= '0;
            mem_req_q <= 1'b0;
            wb_skip_q <= 1'b0;
            sleep_q   <= 1'b0;
            irq_cnt_q <= '0;
            mem_err_q <= 1'b0;
        end else if (!stall) begin
            state_q   <= state_d;
            ex_idx_q  <= ex_idx_d;
            ex_len_q  <= ex_len_d;
            mem_req_q <= mem_req_d;
            wb_skip_q <= wb_skip_d;
            sleep_q   <= sleep_d;
            irq_cnt_q <= irq_cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign estado     = phase_of(state_q);
    assign ex_idx     = ex_idx_q;
    assign irq_cycle  = (state_q == ST_IRQ);
    assign sleeping   = (state_q == ST_SLEEP);
    assign mem_err    = mem_err_q;
    assign instr_done = instr_end && !stall;
    assign irq_ack    = irq_last && !stall;

endmodule
